vh_sweep_checker: RTL
=====================

# vh_sweep_checker

Sequential sweep-and-compare harness for the combinational issue test cases. It drives every value of a DUT's packed input vector in ascending order. For each value it compares two implementations of the same case (reference simulation model vs. synthesized netlist) and records mismatch count, first failing vector and a running output signature. It sits directly upstream (stimulus) and downstream (response) of one issue-case module pair.

## Interface

Parameters:
- IN_WIDTH, 10: width of packed DUT input (e.g. {a,b}); sweep covers 0 .. 2**IN_WIDTH-1.
- OUT_WIDTH, 128: width of DUT output y.
- SETTLE, 2: cycles each vector is held before sampling. Legal values are ≥1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep. Sampled only in IDLE or DONE.
- stop_on_fail  input  1  sampled at start. If 1, abort the sweep at the first mismatch.
- dut_in  output  IN_WIDTH  stimulus to both implementations (registered).
- y_ref  input  OUT_WIDTH  output of reference implementation.
- y_dut  input  OUT_WIDTH  output of implementation under test.
- busy  output  1  sweep in progress.
- done  output  1  sweep finished; held until next start or reset.
- pass  output  1  done && mismatch_count==0.
- mismatch_count  output  16  mismatching vectors, saturates at 16'hFFFF.
- first_fail_in  output  IN_WIDTH  dut_in of first mismatch.
- first_fail_diff  output  OUT_WIDTH  y_ref ^ y_dut at first mismatch.
- signature  output  32  running signature of y_dut.

## Operation

- States: IDLE, RUN, DONE.
- Reset (async, immediate): state IDLE. All outputs are 0: dut_in, busy, done, pass, mismatch_count, first_fail_in, first_fail_diff, signature. Internal settle counter and stop flag are 0.
- Starting a sweep: IDLE/DONE + start=1 at an edge → RUN. The same edge does the following:
  - dut_in←0, settle counter←0;
  - mismatch_count, first_fail_*, signature←0;
  - latches stop_on_fail;
  - busy←1, done←0.
- start while in RUN is ignored.
- RUN, holding a vector: the settle counter increments each edge. The compare edge is the edge where the counter equals SETTLE-1. On that edge:
  - mismatch = (y_ref != y_dut), full width;
  - on mismatch, mismatch_count increments (saturating at 16'hFFFF);
  - on the first mismatch of the sweep only, first_fail_in←dut_in and first_fail_diff←y_ref^y_dut;
  - signature←{signature[30:0],signature[31]} ^ fold(y_dut). fold is the XOR of consecutive 32-bit slices of y_dut, zero-extended to a multiple of 32 bits;
  - settle counter←0 and dut_in←dut_in+1, unless the sweep ends on this edge.
- Ending a sweep: the sweep ends on the compare edge of vector 2**IN_WIDTH-1, or on a mismatching compare edge when stop_on_fail is latched.
  - Next state is DONE, with busy←0, done←1.
  - dut_in holds the last vector (no wrap to 0).
  - The updates to count, first_fail_* and signature on that edge still apply.
- DONE: all outputs hold.

## Timing

- dut_in changes only on compare edges or the start edge. Both implementations see a vector for exactly SETTLE cycles.
- Full sweep: start edge + 2**IN_WIDTH·SETTLE edges. busy is high for exactly 2**IN_WIDTH·SETTLE cycles.
- pass is combinational from done and mismatch_count. It is valid in the same cycle done rises.
- Outputs are registered except pass. y_ref/y_dut are sampled, not registered inputs. Their combinational path is budgeted within SETTLE cycles (multicycle).
- rst asserted mid-sweep aborts at once to the reset values. The next sweep requires a new start.
- Input wrap is impossible: the counter stops at all-ones.
- Simultaneous first mismatch and final vector: capture and DONE both occur.

## Test plan

- IN_WIDTH=2, OUT_WIDTH=2, SETTLE=1, y_dut=y_ref=dut_in. Pulse start → busy high 4 cycles, dut_in 0,1,2,3. Then done=1, pass=1, mismatch_count=0, dut_in=3.
- Same setup, y_dut=y_ref^2'b01 only when dut_in==2 → done after 4 vectors, mismatch_count=1, first_fail_in=2, first_fail_diff=2'b01, pass=0.
- Same fault with stop_on_fail=1 → done after 3 compare edges, dut_in=2, mismatch_count=1.
- y_dut constant 2'b01, y_ref equal → signature=32'h0000000F after the sweep.
- SETTLE=3, IN_WIDTH=2 → each dut_in value held exactly 3 cycles, busy 12 cycles. start pulsed at cycle 5 is ignored.
- Assert rst while dut_in=1 → all outputs are 0 in the same cycle and the state is IDLE. A new start reruns from dut_in=0 with counters cleared.

Source files
------------

// File: rtl/vh_sweep_checker.sv
// Exhaustive input sweep that compares a reference model against a netlist.
// Tracks mismatch count, first failing vector and a rolling output signature.
module vh_sweep_checker #(
  parameter int IN_WIDTH  = 10,
  parameter int OUT_WIDTH = 128,
  parameter int SETTLE    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop_on_fail,
  output logic [IN_WIDTH-1:0]  dut_in,
  input  logic [OUT_WIDTH-1:0] y_ref,
  input  logic [OUT_WIDTH-1:0] y_dut,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          mismatch_count,
  output logic [IN_WIDTH-1:0]  first_fail_in,
  output logic [OUT_WIDTH-1:0] first_fail_diff,
  output logic [31:0]          signature
);

  localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int NSL = (OUT_WIDTH + 31) / 32;
  localparam logic [CW-1:0] CMP_AT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            stop_q;

  logic [NSL*32-1:0] y_pad_d;
  logic [31:0]       fold_d;
  logic [31:0]       sig_d;
  logic              cmp_d;
  logic              mism_d;
  logic              last_d;
  logic              fin_d;
  logic              first_d;

  always_comb begin
    y_pad_d = '0;
    y_pad_d[OUT_WIDTH-1:0] = y_dut;
    fold_d = '0;
    for (int i = 0; i < NSL; i++) begin
      fold_d = fold_d ^ y_pad_d[i*32 +: 32];
    end
  end

  assign sig_d   = {signature[30:0], signature[31]} ^ fold_d;
  assign cmp_d   = (state_q == RUN) && (cnt_q == CMP_AT);
  assign mism_d  = (y_ref != y_dut);
  assign last_d  = (dut_in == '1);
  assign fin_d   = last_d || (mism_d && stop_q);
  // Count never returns to zero once set, so zero means no fail yet
  assign first_d = (mismatch_count == 16'd0);

  assign pass = done && (mismatch_count == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      stop_q          <= 1'b0;
      dut_in          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      mismatch_count  <= '0;
      first_fail_in   <= '0;
      first_fail_diff <= '0;
      signature       <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q         <= RUN;
            cnt_q           <= '0;
            stop_q          <= stop_on_fail;
            dut_in          <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            mismatch_count  <= '0;
            first_fail_in   <= '0;
            first_fail_diff <= '0;
            signature       <= '0;
          end
        end
        RUN: begin
          if (cmp_d) begin
            signature <= sig_d;
            if (mism_d) begin
              if (mismatch_count != 16'hFFFF) begin
                mismatch_count <= mismatch_count + 16'd1;
              end
              if (first_d) begin
                first_fail_in   <= dut_in;
                first_fail_diff <= y_ref ^ y_dut;
              end
            end
            if (fin_d) begin
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              cnt_q  <= '0;
              dut_in <= dut_in + IN_WIDTH'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
